mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store sequencer for the MEM stage of the MIPS datapath, sitting directly upstream of the word-organised data memory (1024 × 32-bit, 10-bit word address, separate read/write enables). It accepts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests from the pipeline and checks alignment and range. It converts each request into word-level memory accesses, using read-modify-write for sub-word stores. Loaded data is returned aligned and zero/sign-extended, with a single-cycle valid strobe.

## Interface
- ADDR_W, 10, word-address width of the data memory; byte-address range is 2^(ADDR_W+2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; request taken on edge where req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned, reserved size or out-of-range
- mem_addr  out  ADDR_W  word index to memory
- mem_din  out  32  write word
- mem_wen  out  1  memory write enable; memory writes on posedge clk
- mem_ren  out  1  memory read enable; mem_dout valid combinationally in the same cycle
- mem_dout  in  32  read word

## Operation
- Byte offset is b = req_addr[1:0]. Word index is req_addr[ADDR_W+1:2]. Little-endian lanes: byte b occupies bits [8b+7:8b]; half at b=0 occupies [15:0], at b=2 occupies [31:16].
- Error conditions:
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - any of req_addr[31:ADDR_W+2] nonzero.
- An erroring request makes no memory access.
- On acceptance, all request fields are latched; the inputs are then don't-care.
- States:
  - IDLE: req_ready=1. On accept: error → RESP; SW → WRITE; load or SB/SH → READ.
  - READ: mem_ren=1, mem_addr = latched index; mem_dout captured at edge.
    - Load → RESP with extracted/extended value.
    - SB/SH → WRITE.
  - WRITE: mem_wen=1. mem_din = req_wdata for SW, or the captured word with the addressed lanes replaced by wdata[7:0]/wdata[15:0]. → RESP.
  - RESP: rsp_valid=1 → IDLE.
- req_ready=0 in every state except IDLE. req_valid outside IDLE is ignored.
- mem_ren and mem_wen are never both high, and each is high only in its own state.
- mem_addr and mem_din are 0 outside READ/WRITE.
- rsp_rdata and rsp_err are registered; they hold until the next RESP.

## Timing
- Reset (sync): state IDLE. Outputs rsp_valid, rsp_rdata, rsp_err, mem_wen, mem_ren, mem_addr, mem_din all 0. req_ready=0 while reset is high and 1 in the first cycle after reset deasserts.
- Latency, with cycle 0 as the acceptance cycle:
  - error: rsp_valid in cycle 1;
  - load: READ in cycle 1, rsp_valid in cycle 2;
  - SW: WRITE in cycle 1, rsp_valid in cycle 2;
  - SB/SH: READ in cycle 1, WRITE in cycle 2, rsp_valid in cycle 3.
- Throughput: the next request can be accepted in the cycle after RESP, i.e. at most one request per 2–4 cycles.
- Reset mid-operation: the unit returns to IDLE on the next edge. No mem_wen or rsp_valid is issued for the abandoned request. A write already performed is not undone.
- Sub-word stores are not atomic against other masters; none exist.

## Structure
- Package mem_access_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state enum ST_IDLE, ST_READ, ST_WRITE, ST_RESP;
  - lane-width constants.
- Sub-module mau_lane_align (combinational) holds both lane functions:
  - load extraction/extension from (word, offset, size, signed);
  - store merge from (old word, wdata, offset, size).
- The top level holds the FSM, request latch and response registers.

## Test plan
1. SW 0xCAFEBABE to byte address 0x3C, then LW 0x3C.
   - Store: mem_addr=15 and mem_wen high exactly one cycle (cycle 1).
   - Load: rsp_rdata=0xCAFEBABE, rsp_valid in cycle 2.
2. SB wdata 0x000000A5 at 0x3D over 0xCAFEBABE.
   - mem_din=0xCAFEA5BE, mem_wen in cycle 2, rsp_valid in cycle 3.
   - LB 0x3D → 0xFFFFFFA5; LBU 0x3D → 0x000000A5.
3. SH wdata 0x8001 at 0x192 over word 100 = 0x12345678.
   - Word becomes 0x80015678.
   - LH 0x192 → 0xFFFF8001; LHU 0x190 → 0x00005678.
4. Error requests: LH 0x191, LW 0x3E, size 11 at 0x40, LW 0x1000 (ADDR_W=10).
   - Each gives rsp_err=1 and rsp_valid in cycle 1, with rsp_rdata=0.
   - mem_ren and mem_wen never assert.
5. Reset asserted during the READ cycle of an SB.
   - mem_wen never asserts and rsp_valid stays 0.
   - req_ready=1 in the first cycle after reset deasserts; all outputs are 0.
6. req_valid held high with two queued requests (LW 0x3C, then SW 0x40).
   - The second is accepted only in the cycle after the first's RESP.
   - req_ready is 0 in every intermediate cycle.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared definitions for the MEM-stage load/store sequencer:
//   - request size encodings (byte / half / word / reserved)
//   - sequencer state encoding
//   - lane-width constants
//   - size/offset alignment check helper
package mem_access_pkg;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    // True when the size is reserved or the byte offset does not suit it.
    function automatic logic size_align_err(input logic [1:0] size,
                                            input logic [1:0] offset);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = offset[0];
            SZ_WORD: err = (offset != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align
// Combinational little-endian lane handling for the load/store sequencer.
//   word       : 32-bit word read from memory
//   offset     : byte offset within the word (address bits [1:0])
//   size       : SZ_BYTE / SZ_HALF / SZ_WORD
//   is_signed  : loads only, 1 = sign-extend, 0 = zero-extend
//   wdata      : right-justified store data
//   load_data  : addressed lane(s) right-justified and extended
//   store_word : word with the addressed lane(s) replaced by wdata
module mau_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [BYTE_W-1:0] byte_lane;
    logic [HALF_W-1:0] half_lane;

    // Load path: select the addressed lane, then extend it to a full word.
    always_comb begin
        byte_lane = 8'h00;
        half_lane = 16'h0000;
        load_data = 32'h0000_0000;
        case (offset)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            2'd3:    byte_lane = word[31:24];
            default: byte_lane = 8'h00;
        endcase
        if (offset[1]) begin
            half_lane = word[31:16];
        end else begin
            half_lane = word[15:0];
        end
        case (size)
            SZ_BYTE: begin
                if (is_signed) begin
                    load_data = {{24{byte_lane[7]}}, byte_lane};
                end else begin
                    load_data = {24'h00_0000, byte_lane};
                end
            end
            SZ_HALF: begin
                if (is_signed) begin
                    load_data = {{16{half_lane[15]}}, half_lane};
                end else begin
                    load_data = {16'h0000, half_lane};
                end
            end
            SZ_WORD: load_data = word;
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Store path: merge the new lane(s) into the previously read word.
    always_comb begin
        store_word = word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    2'd3:    store_word[31:24] = wdata[7:0];
                    default: store_word        = word;
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            SZ_WORD: store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// MEM-stage load/store sequencer in front of a word-organised data memory.
// Accepts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests, checks
// alignment and range, issues word accesses (read-modify-write for
// sub-word stores) and returns an aligned, extended load result.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   req_valid / req_ready      : request handshake (taken when both high)
//   req_we, req_size,
//   req_signed, req_addr,
//   req_wdata                  : request fields, latched on acceptance
//   rsp_valid                  : one-cycle response strobe
//   rsp_rdata, rsp_err         : registered result, held until next response
//   mem_addr, mem_din,
//   mem_wen, mem_ren           : word-level memory controls (all registered)
//   mem_dout                   : read word, valid combinationally with mem_ren
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic [31:0]       mem_dout
);

    state_e            state;
    logic              lat_we;
    logic [1:0]        lat_size;
    logic              lat_signed;
    logic [1:0]        lat_offset;
    logic [31:0]       lat_wdata;

    logic              req_err;
    logic [ADDR_W-1:0] req_index;
    logic [31:0]       load_data;
    logic [31:0]       store_word;

    // Request decode: word index and the combined error condition.
    always_comb begin
        req_index = req_addr[ADDR_W+1:2];
        req_err   = size_align_err(req_size, req_addr[1:0])
                    || ((req_addr >> (ADDR_W + 2)) != 32'h0000_0000);
    end

    // Ready is gated by reset so that it is low for the whole reset
    // window and high in the very first cycle after reset is released.
    assign req_ready = (state == ST_IDLE) && !reset;

    mau_lane_align u_lane_align (
        .word       (mem_dout),
        .offset     (lat_offset),
        .size       (lat_size),
        .is_signed  (lat_signed),
        .wdata      (lat_wdata),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Sequencer FSM with request latch, registered memory controls and
    // registered response. Memory controls are set on entry to READ/WRITE
    // and cleared on exit, so they are high only in their own state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            lat_we     <= 1'b0;
            lat_size   <= 2'b00;
            lat_signed <= 1'b0;
            lat_offset <= 2'b00;
            lat_wdata  <= 32'h0000_0000;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0000_0000;
            rsp_err    <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= 32'h0000_0000;
            mem_wen    <= 1'b0;
            mem_ren    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rsp_valid <= 1'b0;
                    if (req_valid) begin
                        lat_we     <= req_we;
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        lat_offset <= req_addr[1:0];
                        lat_wdata  <= req_wdata;
                        if (req_err) begin
                            // Erroring requests skip memory entirely.
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0000_0000;
                        end else if (req_we && (req_size == SZ_WORD)) begin
                            state    <= ST_WRITE;
                            mem_wen  <= 1'b1;
                            mem_addr <= req_index;
                            mem_din  <= req_wdata;
                        end else begin
                            // Loads and sub-word stores both read first.
                            state    <= ST_READ;
                            mem_ren  <= 1'b1;
                            mem_addr <= req_index;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    mem_ren <= 1'b0;
                    if (lat_we) begin
                        // Keep mem_addr; write back the merged word next.
                        state   <= ST_WRITE;
                        mem_wen <= 1'b1;
                        mem_din <= store_word;
                    end else begin
                        state     <= ST_RESP;
                        mem_addr  <= '0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= load_data;
                        rsp_err   <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    state     <= ST_RESP;
                    mem_wen   <= 1'b0;
                    mem_addr  <= '0;
                    mem_din   <= 32'h0000_0000;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= 32'h0000_0000;
                    rsp_err   <= 1'b0;
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    mem_wen   <= 1'b0;
                    mem_ren   <= 1'b0;
                    mem_addr  <= '0;
                    mem_din   <= 32'h0000_0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Directed self-checking bench for mem_access_unit with a behavioural
// 1024 x 32 data memory (write on posedge, combinational read).
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_dout;

    logic [31:0] mem_model [0:1023];

    int checks   = 0;
    int failures = 0;

    mem_access_unit #(.ADDR_W(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .mem_dout   (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model.
    always @(posedge clk) begin
        if (mem_wen) mem_model[mem_addr] <= mem_din;
    end
    assign mem_dout = mem_ren ? mem_model[mem_addr] : 32'h0000_0000;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Issue one request, follow it to its response and check the observed
    // memory activity (bit k-1 of a mask = cycle k after acceptance).
    task automatic txn(input string tag, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                       input int exp_cyc, input logic [31:0] exp_rdata, input logic exp_err,
                       input logic [7:0] exp_ren, input logic [7:0] exp_wen,
                       input logic [31:0] exp_din, input logic [31:0] exp_maddr);
        int          rsp_cyc;
        int          ready_hi;
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  ren_mask;
        logic [7:0]  wen_mask;
        logic [31:0] wen_din;
        logic [31:0] acc_addr;
        rsp_cyc = -1; ready_hi = 0; rdata = 32'h0; err = 1'b0;
        ren_mask = 8'h00; wen_mask = 8'h00; wen_din = 32'h0; acc_addr = 32'h0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        check_eq({tag, ".accept_ready"}, {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 8 && rsp_cyc < 0; k++) begin
            @(negedge clk);
            if (mem_ren) begin ren_mask[k-1] = 1'b1; acc_addr = {22'h0, mem_addr}; end
            if (mem_wen) begin wen_mask[k-1] = 1'b1; wen_din = mem_din; acc_addr = {22'h0, mem_addr}; end
            if (req_ready) ready_hi++;
            if (rsp_valid) begin rsp_cyc = k; rdata = rsp_rdata; err = rsp_err; end
        end
        check_eq({tag, ".rsp_cycle"}, rsp_cyc, exp_cyc);
        check_eq({tag, ".rdata"}, rdata, exp_rdata);
        check_eq({tag, ".err"}, {31'h0, err}, {31'h0, exp_err});
        check_eq({tag, ".ren_cycles"}, {24'h0, ren_mask}, {24'h0, exp_ren});
        check_eq({tag, ".wen_cycles"}, {24'h0, wen_mask}, {24'h0, exp_wen});
        check_eq({tag, ".busy_ready"}, ready_hi, 32'd0);
        if (exp_wen != 8'h00) check_eq({tag, ".mem_din"}, wen_din, exp_din);
        if ((exp_ren | exp_wen) != 8'h00) check_eq({tag, ".mem_addr"}, acc_addr, exp_maddr);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, ".rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
        check_eq({tag, ".rsp_rdata"}, rsp_rdata, 32'h0);
        check_eq({tag, ".rsp_err"}, {31'h0, rsp_err}, 32'h0);
        check_eq({tag, ".mem_wen"}, {31'h0, mem_wen}, 32'h0);
        check_eq({tag, ".mem_ren"}, {31'h0, mem_ren}, 32'h0);
        check_eq({tag, ".mem_addr"}, {22'h0, mem_addr}, 32'h0);
        check_eq({tag, ".mem_din"}, mem_din, 32'h0);
    endtask

    initial begin
        logic [7:0] rdy_v, rspv_v, wen_v, ren_v;
        logic [31:0] t6_rdata, t6_din, t6_waddr;
        int          bad;

        for (int i = 0; i < 1024; i++) mem_model[i] = 32'h0;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst.ready_in_reset", {31'h0, req_ready}, 32'h0);
        check_idle_outputs("rst");
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst.ready_after", {31'h0, req_ready}, 32'h1);

        // 1: SW then LW
        txn("sw3c", 1'b1, 2'b10, 1'b0, 32'h3C, 32'hCAFEBABE, 2, 32'h0, 1'b0, 8'h00, 8'h01, 32'hCAFEBABE, 32'd15);
        txn("lw3c", 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 2, 32'hCAFEBABE, 1'b0, 8'h01, 8'h00, 32'h0, 32'd15);

        // 2: SB read-modify-write, then signed/unsigned byte loads
        txn("sb3d", 1'b1, 2'b00, 1'b0, 32'h3D, 32'h000000A5, 3, 32'h0, 1'b0, 8'h01, 8'h02, 32'hCAFEA5BE, 32'd15);
        txn("lb3d", 1'b0, 2'b00, 1'b1, 32'h3D, 32'h0, 2, 32'hFFFFFFA5, 1'b0, 8'h01, 8'h00, 32'h0, 32'd15);
        txn("lbu3d", 1'b0, 2'b00, 1'b0, 32'h3D, 32'h0, 2, 32'h000000A5, 1'b0, 8'h01, 8'h00, 32'h0, 32'd15);

        // 3: SH into the upper half of word 100
        txn("sw190", 1'b1, 2'b10, 1'b0, 32'h190, 32'h12345678, 2, 32'h0, 1'b0, 8'h00, 8'h01, 32'h12345678, 32'd100);
        txn("sh192", 1'b1, 2'b01, 1'b0, 32'h192, 32'h00008001, 3, 32'h0, 1'b0, 8'h01, 8'h02, 32'h80015678, 32'd100);
        txn("lh192", 1'b0, 2'b01, 1'b1, 32'h192, 32'h0, 2, 32'hFFFF8001, 1'b0, 8'h01, 8'h00, 32'h0, 32'd100);
        txn("lhu190", 1'b0, 2'b01, 1'b0, 32'h190, 32'h0, 2, 32'h00005678, 1'b0, 8'h01, 8'h00, 32'h0, 32'd100);

        // 4: error requests (preceding rsp_rdata is nonzero)
        txn("err_lh191", 1'b0, 2'b01, 1'b1, 32'h191, 32'h0, 1, 32'h0, 1'b1, 8'h00, 8'h00, 32'h0, 32'h0);
        txn("err_lw3e", 1'b0, 2'b10, 1'b0, 32'h3E, 32'h0, 1, 32'h0, 1'b1, 8'h00, 8'h00, 32'h0, 32'h0);
        txn("err_sz11", 1'b1, 2'b11, 1'b0, 32'h40, 32'h11111111, 1, 32'h0, 1'b1, 8'h00, 8'h00, 32'h0, 32'h0);
        txn("err_lw1000", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1, 32'h0, 1'b1, 8'h00, 8'h00, 32'h0, 32'h0);
        txn("ok_after_err", 1'b0, 2'b10, 1'b0, 32'h190, 32'h0, 2, 32'h80015678, 1'b0, 8'h01, 8'h00, 32'h0, 32'd100);

        // 5: reset during the READ cycle of an SB
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h3D; req_wdata = 32'h0000005A;
        check_eq("rstmid.accept_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check_eq("rstmid.read_cycle", {31'h0, mem_ren}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rstmid.ready_after", {31'h0, req_ready}, 32'h1);
        check_idle_outputs("rstmid");
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (mem_wen || rsp_valid) bad++;
            @(negedge clk);
        end
        check_eq("rstmid.no_wen_rsp", bad, 32'd0);
        txn("rstmid_lb3d", 1'b0, 2'b00, 1'b1, 32'h3D, 32'h0, 2, 32'hFFFFFFA5, 1'b0, 8'h01, 8'h00, 32'h0, 32'd15);

        // 6: back-to-back requests with req_valid held high
        rdy_v = 8'h00; rspv_v = 8'h00; wen_v = 8'h00; ren_v = 8'h00;
        t6_rdata = 32'h0; t6_din = 32'h0; t6_waddr = 32'h0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h3C; req_wdata = 32'h0;
        check_eq("b2b.accept_ready", {31'h0, req_ready}, 32'h1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            rdy_v[k]  = req_ready;
            rspv_v[k] = rsp_valid;
            wen_v[k]  = mem_wen;
            ren_v[k]  = mem_ren;
            if (rsp_valid && k == 2) t6_rdata = rsp_rdata;
            if (mem_wen) begin t6_din = mem_din; t6_waddr = {22'h0, mem_addr}; end
            if (k == 1) begin req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h0BADF00D; end
            if (k == 4) req_valid = 1'b0;
        end
        check_eq("b2b.ready_seq", {24'h0, rdy_v}, 32'h08);
        check_eq("b2b.rsp_seq", {24'h0, rspv_v}, 32'h24);
        check_eq("b2b.wen_seq", {24'h0, wen_v}, 32'h10);
        check_eq("b2b.ren_seq", {24'h0, ren_v}, 32'h02);
        check_eq("b2b.lw_rdata", t6_rdata, 32'hCAFEA5BE);
        check_eq("b2b.sw_din", t6_din, 32'h0BADF00D);
        check_eq("b2b.sw_addr", t6_waddr, 32'd16);
        txn("lw40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 2, 32'h0BADF00D, 1'b0, 8'h01, 8'h00, 32'h0, 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
